// File: rtl/instr_load_pkg.sv
// Shared state encoding and opcode constants for the instruction load sequencer
// and its control decoder.
package instr_load_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_e;

  localparam int OPC_W = 6;
  localparam logic [OPC_W-1:0] TERM_OPCODE_DEF = 6'b000000;

  function automatic logic opc_is_term(input logic [OPC_W-1:0] opc,
                                       input logic [OPC_W-1:0] term);
    return opc == term;
  endfunction

endpackage

// File: rtl/instr_addr_counter.sv
// Write pointer and word counter for the load sequencer: the pointer wraps at
// DEPTH, the count saturates at DEPTH, and full is reported only when not wrapping.
module instr_addr_counter #(
  parameter int DEPTH   = 256,
  parameter bit WRAP_EN = 1'b0,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              clear_i,
  input  logic              incr_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              wrap_o
);

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (clear_i) begin
      ptr_d   = '0;
      count_d = '0;
    end else if (incr_i) begin
      // Explicit wrap keeps non-power-of-two depths inside the memory.
      ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
      count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  assign ptr_o   = ptr_q;
  assign count_o = count_q;
  assign full_o  = !WRAP_EN && (count_q == CNT_MAX);
  assign wrap_o  = WRAP_EN && incr_i && !clear_i && (ptr_q == PTR_LAST);

endmodule

// File: rtl/instr_load_sequencer.sv
// Streams instruction words into instruction memory and closes a load on a terminator
// opcode. Optional XOR checksum of written words: define INSTR_LOAD_CHECKSUM_EN.
module instr_load_sequencer
  import instr_load_pkg::*;
#(
  parameter int DATA_W                  = 32,
  parameter int DEPTH                   = 256,
  parameter int OPC_MSB                 = 31,
  parameter logic [OPC_W-1:0] TERM_OPCODE = TERM_OPCODE_DEF,
  parameter bit WRAP_EN                 = 1'b0,
  parameter bit STORE_TERM              = 1'b0,
  localparam int ADDR_W                 = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              instrValid,
  input  logic [DATA_W-1:0] instrIn,
  output logic              instrReady,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memData,
  output logic [ADDR_W:0]   wordCount,
  output logic              busy,
  output logic              loadDone,
  output logic              full,
  output logic              overflow
`ifdef INSTR_LOAD_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  load_state_e state_q, state_d;

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  logic              overflow_q;

  logic [ADDR_W-1:0] ptr;
  logic              full_w, wrap_w;
  logic              accept, is_term, write_en, cnt_clear, offer_full;

  assign instrReady = (state_q == LOAD) && !full_w;
  // A start in LOAD restarts the image, so the word offered alongside it is dropped.
  assign accept     = instrValid && instrReady && !start;
  assign is_term    = opc_is_term(instrIn[OPC_MSB -: OPC_W], TERM_OPCODE);
  assign write_en   = accept && (!is_term || STORE_TERM);
  assign cnt_clear  = start && (state_q != DONE);
  assign offer_full = (state_q == LOAD) && full_w && instrValid && !start;

  instr_addr_counter #(
    .DEPTH   (DEPTH),
    .WRAP_EN (WRAP_EN)
  ) u_addr_counter (
    .clk     (clock),
    .srst    (reset),
    .clear_i (cnt_clear),
    .incr_i  (write_en),
    .ptr_o   (ptr),
    .count_o (wordCount),
    .full_o  (full_w),
    .wrap_o  (wrap_w)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: if ((accept && is_term) || offer_full) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_we_q <= write_en;
      if (write_en) begin
        mem_addr_q <= ptr;
        mem_data_q <= instrIn;
      end else if (start && state_q == IDLE) begin
        mem_addr_q <= '0;
      end
      if (cnt_clear)                overflow_q <= 1'b0;
      else if (wrap_w || offer_full) overflow_q <= 1'b1;
    end
  end

`ifdef INSTR_LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clock) begin
    if (reset || cnt_clear) checksum_q <= '0;
    else if (write_en)      checksum_q <= checksum_q ^ instrIn;
  end

  assign checksum = checksum_q;
`endif

  assign memWe    = mem_we_q;
  assign memAddr  = mem_addr_q;
  assign memData  = mem_data_q;
  assign busy     = (state_q == LOAD);
  assign loadDone = (state_q == DONE);
  assign full     = full_w;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_instr_load_sequencer.sv
// Three DEPTH=8 sequencers on shared stimulus: u0 plain, u1 storing the
// terminator, u2 wrapping; each has its own expected-event queue.
module tb_instr_load_sequencer;

  typedef struct {
    bit          is_done;
    logic [2:0]  addr;
    logic [31:0] data;   // write data, or checksum for a done event
    logic [3:0]  cnt;
    logic        ovf;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr_in = '0;

  logic        instr_ready [3];
  logic        mem_we      [3];
  logic [2:0]  mem_addr    [3];
  logic [31:0] mem_data    [3];
  logic [3:0]  word_count  [3];
  logic        busy        [3];
  logic        load_done   [3];
  logic        full        [3];
  logic        overflow    [3];
  logic [31:0] cs_w        [3];

  ev_t exp_q [3][$];
  int  errors = 0;
  int  checks = 0;

  localparam logic [31:0] W1 = 32'h0400_0001, W2 = 32'h0800_0002, W3 = 32'h1000_0004;
  localparam logic [31:0] TW = 32'h0000_0008;
  localparam logic [31:0] A0 = 32'h0400_00A0, A1 = 32'h0400_00A1;
  localparam logic [31:0] AX = 32'h0400_00FF, B0 = 32'h0400_00B0;
  localparam logic [31:0] D0 = 32'h0400_00D0, D1 = 32'h0400_00D1, D2 = 32'h0400_00D2;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    instr_load_sequencer #(
      .DATA_W      (32),
      .DEPTH       (8),
      .OPC_MSB     (31),
      .TERM_OPCODE (6'b000000),
      .WRAP_EN     (gi == 2),
      .STORE_TERM  (gi == 1)
    ) dut (
      .clock      (clk),
      .reset      (reset),
      .start      (start),
      .instrValid (instr_valid),
      .instrIn    (instr_in),
      .instrReady (instr_ready[gi]),
      .memWe      (mem_we[gi]),
      .memAddr    (mem_addr[gi]),
      .memData    (mem_data[gi]),
      .wordCount  (word_count[gi]),
      .busy       (busy[gi]),
      .loadDone   (load_done[gi]),
      .full       (full[gi]),
      .overflow   (overflow[gi])
`ifdef INSTR_LOAD_CHECKSUM_EN
      ,
      .checksum   (cs_w[gi])
`endif
    );
`ifndef INSTR_LOAD_CHECKSUM_EN
    assign cs_w[gi] = '0;
`endif
  end

  task automatic exp_w(input bit [2:0] mask, input logic [2:0] a, input logic [31:0] d);
    for (int i = 0; i < 3; i++)
      if (mask[i]) exp_q[i].push_back('{is_done: 1'b0, addr: a, data: d, cnt: 4'd0, ovf: 1'b0});
  endtask

  task automatic exp_d(input bit [2:0] mask, input logic [3:0] c, input logic o, input logic [31:0] cs);
    for (int i = 0; i < 3; i++)
      if (mask[i]) exp_q[i].push_back('{is_done: 1'b1, addr: 3'd0, data: cs, cnt: c, ovf: o});
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic v, input logic [31:0] w);
    start       = s;
    instr_valid = v;
    instr_in    = w;
    tick();
    start       = 1'b0;
    instr_valid = 1'b0;
  endtask

  task automatic chk_reset_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_u%0d", tag, i),
          {19'd0, mem_we[i], mem_addr[i], mem_data[i], word_count[i], busy[i],
           load_done[i], full[i], overflow[i], instr_ready[i]}, 64'd0);
`ifdef INSTR_LOAD_CHECKSUM_EN
      chk($sformatf("%s_cs_u%0d", tag, i), {32'd0, cs_w[i]}, 64'd0);
`endif
    end
  endtask

  // Monitor: every write and every loadDone pulse consumes one expected event.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      ev_t e;
      logic cs_bad;
      if (mem_we[i] === 1'b1) begin
        checks++;
        if (exp_q[i].size() == 0) begin
          errors++;
          $display("FAIL write_u%0d: unexpected write addr=%0d data=%h", i, mem_addr[i], mem_data[i]);
        end else begin
          e = exp_q[i].pop_front();
          if (e.is_done || e.addr !== mem_addr[i] || e.data !== mem_data[i]) begin
            errors++;
            $display("FAIL write_u%0d: got addr=%0d data=%h want done=%0d addr=%0d data=%h",
                     i, mem_addr[i], mem_data[i], e.is_done, e.addr, e.data);
          end else
            $display("write u%0d addr=%0d data=%h ok", i, mem_addr[i], mem_data[i]);
        end
      end
      if (load_done[i] === 1'b1) begin
        checks++;
        if (exp_q[i].size() == 0) begin
          errors++;
          $display("FAIL done_u%0d: unexpected loadDone count=%0d", i, word_count[i]);
        end else begin
          e = exp_q[i].pop_front();
          cs_bad = 1'b0;
`ifdef INSTR_LOAD_CHECKSUM_EN
          cs_bad = (e.data !== cs_w[i]);
`endif
          if (!e.is_done || e.cnt !== word_count[i] || e.ovf !== overflow[i] || cs_bad) begin
            errors++;
            $display("FAIL done_u%0d: got count=%0d ovf=%0d cs=%h want done=%0d count=%0d ovf=%0d cs=%h",
                     i, word_count[i], overflow[i], cs_w[i], e.is_done, e.cnt, e.ovf, e.data);
          end else
            $display("done u%0d count=%0d ovf=%0d ok", i, word_count[i], overflow[i]);
        end
      end
    end
  end

  initial begin
    tick();
    tick();
    chk_reset_all("reset_state");
    reset = 1'b0;
    tick();

    // Three words then a terminator.
    exp_w(3'b111, 3'd0, W1);
    exp_w(3'b111, 3'd1, W2);
    exp_w(3'b111, 3'd2, W3);
    exp_w(3'b010, 3'd3, TW);
    exp_d(3'b101, 4'd3, 1'b0, 32'h1C00_0007);
    exp_d(3'b010, 4'd4, 1'b0, 32'h1C00_000F);
    drive(1'b1, 1'b0, '0);
    chk("busy_after_start", {63'd0, busy[0]}, 64'd1);
    drive(1'b0, 1'b1, W1);
    drive(1'b0, 1'b1, W2);
    drive(1'b0, 1'b1, W3);
    drive(1'b0, 1'b1, TW);
    repeat (3) tick();

    // Nine/ten plain words: u0/u1 fill and overflow, u2 wraps.
    for (int k = 0; k < 8; k++) exp_w(3'b111, 3'(k), 32'h0400_0000 | k);
    exp_w(3'b100, 3'd0, 32'h0400_0008);
    exp_w(3'b100, 3'd1, 32'h0400_0009);
    exp_d(3'b011, 4'd8, 1'b1, 32'h0000_0000);
    exp_d(3'b100, 4'd8, 1'b1, 32'h0000_0001);
    drive(1'b1, 1'b0, '0);
    for (int k = 0; k < 8; k++) drive(1'b0, 1'b1, 32'h0400_0000 | k);
    chk("full_u0_after_8", {63'd0, full[0]}, 64'd1);
    chk("ready_u0_full", {63'd0, instr_ready[0]}, 64'd0);
    chk("ovf_u0_before_9th", {63'd0, overflow[0]}, 64'd0);
    chk("full_u2_wrap", {63'd0, full[2]}, 64'd0);
    chk("ovf_u2_first_wrap", {63'd0, overflow[2]}, 64'd1);
    chk("count_u0_sat", {60'd0, word_count[0]}, 64'd8);
    drive(1'b0, 1'b1, 32'h0400_0008);
    drive(1'b0, 1'b1, 32'h0400_0009);
    drive(1'b0, 1'b1, TW);
    repeat (3) tick();

    // Gapped valid with an abort after two words.
    exp_w(3'b111, 3'd0, A0);
    exp_w(3'b111, 3'd1, A1);
    exp_w(3'b111, 3'd0, B0);
    exp_w(3'b010, 3'd1, TW);
    exp_d(3'b101, 4'd1, 1'b0, B0);
    exp_d(3'b010, 4'd2, 1'b0, B0 ^ TW);
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, A0);
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, A1);
    drive(1'b1, 1'b1, AX);
    chk("abort_count_u0", {60'd0, word_count[0]}, 64'd0);
    chk("abort_busy_u0", {63'd0, busy[0]}, 64'd1);
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, B0);
    drive(1'b0, 1'b1, TW);
    repeat (3) tick();

    // Reset in the middle of a burst.
    exp_w(3'b111, 3'd0, D0);
    exp_w(3'b111, 3'd1, D1);
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, D0);
    drive(1'b0, 1'b1, D1);
    reset       = 1'b1;
    instr_valid = 1'b1;
    instr_in    = D2;
    tick();
    chk_reset_all("reset_mid_burst");
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("no_write_after_reset_%0d", k), {63'd0, mem_we[0]}, 64'd0);
    end
    instr_valid = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 3; i++)
      chk($sformatf("events_left_u%0d", i), 64'(exp_q[i].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
